rr_arbiter8: RTL and testbench

Eight-requester round-robin arbiter that shares one downstream resource between up to eight clients. Each arbitration rotates the request vector by a rotating priority pointer and resolves the winner with a lowest-set-bit priority encoder. The grant is held until the winner signals `done`, drops its request, or exceeds a hold-time limit. It sits between client request lines and the shared resource's select/mux input.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/rr_arbiter8_prio_enc8.sv | 28 ++
 rtl/rr_arbiter8.sv | 143 ++++++++++++++
 tb/tb_rr_arbiter8.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the eight-way round-robin arbiter.
//   ARB_N       : number of requesters (8)
//   ARB_W       : width of a requester index (3)
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   onehot()    : converts a requester index to its one-hot grant vector
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int ARB_N = 8;
  localparam int ARB_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Turns a requester index into the matching single-bit grant vector.
  function automatic logic [ARB_N-1:0] onehot(input logic [ARB_W-1:0] idx);
    logic [ARB_N-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_arbiter8_prio_enc8.sv
// ---------------------------------------------------------------------------
// prio_enc8
// Combinational lowest-set-bit priority encoder for an 8-bit vector.
//   in  [7:0] : vector to encode
//   pos [2:0] : index of the lowest set bit of in (0 when in is all zeros)
//   any       : in has at least one bit set
// ---------------------------------------------------------------------------
module prio_enc8
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0] in,
  output logic [ARB_W-1:0] pos,
  output logic             any
);

  // Scanning from the top down lets the lowest set bit overwrite any higher
  // one, so the last match wins and pos settles on the lowest index.
  always_comb begin
    pos = '0;
    any = |in;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (in[i]) begin
        pos = ARB_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
// Eight-requester round-robin arbiter with a per-grant hold-time limit.
// A grant is held until the winner raises done, drops its request, or has
// held the resource for MAX_HOLD cycles. Every release is followed by one
// idle cycle before the next arbitration.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   req [7:0] : request lines, bit i belongs to client i
//   done      : current grantee is finished (ignored while idle)
//   gnt [7:0] : one-hot grant, all zeros when nothing is granted
//   gnt_id    : index of the granted client, 0 when nothing is granted
//   gnt_valid : a grant is active
//   timeout   : one-cycle pulse when a grant hit the hold limit
// ---------------------------------------------------------------------------
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [ARB_W-1:0] gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [ARB_W-1:0] ptr_q, ptr_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [ARB_W-1:0] gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  logic [ARB_N-1:0] rot;
  logic [ARB_W-1:0] rot_pos;
  logic             rot_any;
  logic [ARB_W-1:0] winner;
  logic             client_release;
  logic             hold_expired;

  // Rotate the requests right by the pointer so that the client at ptr
  // lands in bit 0; the 3-bit index sum wraps naturally around the ring.
  always_comb begin
    rot = '0;
    for (int i = 0; i < ARB_N; i++) begin
      rot[i] = req[ARB_W'(i) + ptr_q];
    end
  end

  prio_enc8 u_prio_enc8 (
    .in  (rot),
    .pos (rot_pos),
    .any (rot_any)
  );

  // Undo the rotation: the encoder position is relative to ptr.
  assign winner = rot_pos + ptr_q;

  // A client-initiated release takes precedence over the hold limit, so a
  // timeout is only reported when the grantee did not give up on its own.
  assign client_release = done | ~req[gnt_id_q];
  assign hold_expired   = (hold_cnt_q == HOLD_LAST);

  // Next-state logic: arbitrate in IDLE, hold and count in GRANT, and on
  // release advance the pointer past the grantee and clear the outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        hold_cnt_d  = '0;
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
        if (rot_any) begin
          gnt_d       = onehot(winner);
          gnt_id_d    = winner;
          gnt_valid_d = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (client_release || hold_expired) begin
          state_d     = IDLE;
          ptr_d       = gnt_id_q + ARB_W'(1);
          hold_cnt_d  = '0;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          timeout_d   = hold_expired & ~client_release;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset returns everything to idle with the
  // pointer at client 0 and no completion or timeout reported.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter8
// Directed testbench for rr_arbiter8. Inputs change just after the falling
// edge and outputs are sampled on the following falling edge, so each
// observation reflects exactly one rising edge of the DUT.
// ---------------------------------------------------------------------------
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks;
  int errors;

  rr_arbiter8 #(
    .N        (8),
    .MAX_HOLD (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Returns the bench to a known idle state (pointer at 0) without checking.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Outputs held at zero through reset even with every client requesting,
  // then client 0 wins first once reset is released.
  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc%0d got gnt=%h id=%0d v=%b to=%b want 00/0/0/0",
                 c, gnt, gnt_id, gnt_valid, timeout);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_first_grant got gnt=%h id=%0d v=%b to=%b want 01/0/1/0",
               gnt, gnt_id, gnt_valid, timeout);
    end
  endtask

  // Lone client 3 is granted after one cycle, releases on done, and the
  // pointer then sits at 4 so client 4 beats the rest of a full request.
  task automatic test_single();
    do_reset();
    req = 8'h08;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL single_grant cyc%0d got gnt=%h id=%0d v=%b to=%b want 08/3/1/0",
                 c, gnt, gnt_id, gnt_valid, timeout);
      end
    end
    done = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL single_release got gnt=%h id=%0d v=%b to=%b want 00/0/0/0",
               gnt, gnt_id, gnt_valid, timeout);
    end
    done = 1'b0;
    req  = 8'hFF;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h10, 3'd4, 1'b1}) begin
      errors++;
      $display("[TB] FAIL single_ptr4 got gnt=%h id=%0d v=%b want 10/4/1",
               gnt, gnt_id, gnt_valid);
    end
    req = 8'h00;
    @(negedge clk);
    checks++;
    if ({gnt_valid, timeout} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL single_drop got v=%b to=%b want 0/0", gnt_valid, timeout);
    end
  endtask

  // Everyone requests; each grant is ended with done, giving 0..7 then 0,
  // with an idle bubble between consecutive grants.
  task automatic test_fairness();
    logic [7:0] exp_gnt;
    logic [2:0] exp_id;
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      exp_id  = 3'(g % 8);
      exp_gnt = 8'h01 << exp_id;
      @(negedge clk);
      checks++;
      if ({gnt, gnt_id, gnt_valid} !== {exp_gnt, exp_id, 1'b1}) begin
        errors++;
        $display("[TB] FAIL fair_grant%0d got gnt=%h id=%0d v=%b want %h/%0d/1",
                 g, gnt, gnt_id, gnt_valid, exp_gnt, exp_id);
      end
      done = 1'b1;
      @(negedge clk);
      checks++;
      if ({gnt, gnt_valid, timeout} !== {8'h00, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL fair_bubble%0d got gnt=%h v=%b to=%b want 00/0/0",
                 g, gnt, gnt_valid, timeout);
      end
      done = 1'b0;
    end
    req = 8'h00;
    @(negedge clk);
  endtask

  // With the pointer at 1, client 7 comes before client 0; after 7 releases
  // the pointer wraps to 0 and client 0 follows.
  task automatic test_wrap();
    do_reset();
    req = 8'h01;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 8'h81;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h80, 3'd7, 1'b1}) begin
      errors++;
      $display("[TB] FAIL wrap_first7 got gnt=%h id=%0d v=%b want 80/7/1",
               gnt, gnt_id, gnt_valid);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL wrap_then0 got gnt=%h id=%0d v=%b want 01/0/1",
               gnt, gnt_id, gnt_valid);
    end
    done = 1'b1;
    req  = 8'h00;
    @(negedge clk);
    done = 1'b0;
  endtask

  // Client 2 holds without done: exactly 16 cycles of grant, one timeout
  // pulse during the bubble, then client 2 is granted again.
  task automatic test_timeout();
    int hi_cycles;
    do_reset();
    req       = 8'h04;
    hi_cycles = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (gnt_valid === 1'b1 && gnt_id === 3'd2 && timeout === 1'b0) hi_cycles++;
    end
    checks++;
    if (hi_cycles !== 16) begin
      errors++;
      $display("[TB] FAIL timeout_hold_len got %0d cycles want 16", hi_cycles);
    end
    @(negedge clk);
    checks++;
    if ({gnt, gnt_valid, timeout} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL timeout_pulse got gnt=%h v=%b to=%b want 00/0/1",
               gnt, gnt_valid, timeout);
    end
    @(negedge clk);
    checks++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL timeout_regrant got gnt=%h id=%0d v=%b to=%b want 04/2/1/0",
               gnt, gnt_id, gnt_valid, timeout);
    end
    req = 8'h00;
    @(negedge clk);
  endtask

  // done arriving on the very cycle the hold limit is reached counts as a
  // normal completion, so no timeout pulse is produced.
  task automatic test_done_at_limit();
    do_reset();
    req = 8'h04;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
    end
    done = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt_valid, timeout} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL limit_with_done got v=%b to=%b want 0/0", gnt_valid, timeout);
    end
    done = 1'b0;
    req  = 8'h00;
    @(negedge clk);
  endtask

  // done while idle is ignored; a request in the same cycle is still granted.
  task automatic test_done_idle();
    do_reset();
    done = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt_valid, timeout} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL idle_done got v=%b to=%b want 0/0", gnt_valid, timeout);
    end
    req = 8'h02;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h02, 3'd1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL idle_done_grant got gnt=%h id=%0d v=%b want 02/1/1",
               gnt, gnt_id, gnt_valid);
    end
    done = 1'b0;
    req  = 8'h00;
    @(negedge clk);
  endtask

  // Reset during a grant clears everything and returns the pointer to 0;
  // other requests changing mid-grant leave the grant alone, and the
  // grantee dropping its request releases without a timeout.
  task automatic test_reset_mid_and_drop();
    do_reset();
    req = 8'h10;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midreset_clear got gnt=%h id=%0d v=%b to=%b want 00/0/0/0",
               gnt, gnt_id, gnt_valid, timeout);
    end
    rst_n = 1'b1;
    req   = 8'hFF;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL midreset_ptr0 got gnt=%h id=%0d v=%b want 01/0/1",
               gnt, gnt_id, gnt_valid);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 8'h20;
    @(negedge clk);
    req = 8'h23;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_id, gnt_valid} !== {8'h20, 3'd5, 1'b1}) begin
      errors++;
      $display("[TB] FAIL drop_others_change got gnt=%h id=%0d v=%b want 20/5/1",
               gnt, gnt_id, gnt_valid);
    end
    req = 8'h00;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_valid, timeout} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL drop_release got gnt=%h v=%b to=%b want 00/0/0",
               gnt, gnt_valid, timeout);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 8'h00;
    done   = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_timeout();
    test_done_at_limit();
    test_done_idle();
    test_reset_mid_and_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
